// File: rtl/sig_pkg.sv
// Shared types and default sizing for the sample capture/replay engine.
// The state encoding is exported so other signal-path blocks can decode busy phases.
package sig_pkg;

   localparam int DEF_A_WIDTH = 9;
   localparam int DEF_D_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } cap_state_t;

   // Capture length as an A_WIDTH+1 bit count, where a zero request means full depth.
   function automatic logic [DEF_A_WIDTH:0] lenToCount(input logic [DEF_A_WIDTH-1:0] len);
      lenToCount = (len == '0) ? {1'b1, {DEF_A_WIDTH{1'b0}}} : {1'b0, len};
   endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
// The read output register only loads on a read request, so it holds its data under back-pressure.
module sample_ram
   import sig_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wrEn_i,
   input  logic [A_WIDTH-1:0] wrAddr_i,
   input  logic [D_WIDTH-1:0] wrData_i,
   input  logic               rdEn_i,
   input  logic [A_WIDTH-1:0] rdAddr_i,
   output logic [D_WIDTH-1:0] rdData_o
);

   logic [D_WIDTH-1:0] mem [2**A_WIDTH];
   logic [D_WIDTH-1:0] rdData_q;

   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
   end

   // The array itself is never reset; only the output register is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= mem[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/sig_capture_player.sv
// Record-then-replay engine: captures len samples on the en strobe, then replays
// them as a valid/ready stream, optionally looping without bubbles at the wrap.
module sig_capture_player
   import sig_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] len,
   input  logic               loop,
   input  logic               en,
   input  logic [D_WIDTH-1:0] din,
   output logic [D_WIDTH-1:0] dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               busy,
   output logic               done
);

   localparam logic [A_WIDTH:0]   CNT_ONE = (A_WIDTH+1)'(1);
   localparam logic [A_WIDTH-1:0] PTR_ONE = A_WIDTH'(1);

   cap_state_t         state_q, state_d;
   logic [A_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [A_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [A_WIDTH:0]   len_q, len_d;
   logic [A_WIDTH:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               wrEn;
   logic               wrapRead;
   logic               lastHs;
   logic               readIssue;
   logic [A_WIDTH-1:0] rdAddr;
   logic [A_WIDTH:0]   lenFull;

   always_comb begin
      lenFull = (len == '0) ? {1'b1, {A_WIDTH{1'b0}}} : {1'b0, len};
   end

   // During PLAY cnt_q counts reads issued in the current pass; once it reaches len_q
   // the sample sitting in dout is the last one, and a new read must restart at address 0.
   always_comb begin
      wrEn      = (state_q == RECORD) && en;
      wrapRead  = (cnt_q == len_q);
      lastHs    = (state_q == PLAY) && wrapRead && valid_q && dout_ready;
      readIssue = (state_q == PLAY) && (!wrapRead || (lastHs && loop)) &&
                  (!valid_q || dout_ready);
      rdAddr    = wrapRead ? '0 : rdPtr_q;
   end

   always_comb begin
      state_d = state_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      valid_d = readIssue || (valid_q && !dout_ready);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RECORD;
               len_d   = lenFull;
               wrPtr_d = '0;
               cnt_d   = '0;
            end
         end
         RECORD: begin
            if (en) begin
               wrPtr_d = wrPtr_q + PTR_ONE;
               cnt_d   = cnt_q + CNT_ONE;
               if (cnt_q == len_q - CNT_ONE) begin
                  state_d = PLAY;
                  rdPtr_d = '0;
                  cnt_d   = '0;
               end
            end
         end
         PLAY: begin
            if (readIssue) begin
               rdPtr_d = rdAddr + PTR_ONE;
               cnt_d   = wrapRead ? CNT_ONE : cnt_q + CNT_ONE;
            end
            if (lastHs && !loop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   sample_ram #(
      .A_WIDTH (A_WIDTH),
      .D_WIDTH (D_WIDTH)
   ) uRam (
      .clk      (clk),
      .rst      (rst),
      .wrEn_i   (wrEn),
      .wrAddr_i (wrPtr_q),
      .wrData_i (din),
      .rdEn_i   (readIssue),
      .rdAddr_i (rdAddr),
      .rdData_o (dout)
   );

   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sig_capture_player.sv
// Directed bench for sig_capture_player at A_WIDTH=3: capture/replay, back-pressure,
// full-depth length, looping, ignored start pulses and mid-playback reset.
module tb_sig_capture_player;

   localparam int AW = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] len = '0;
   logic          loop = 1'b0;
   logic          en = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          busy;
   logic          done;

   int assertCount = 0;
   int failCount   = 0;

   int stim [16];
   int expd [16];
   int got [$];
   int gotCyc [$];
   int cycle      = 0;
   int doneCount  = 0;
   int readyMode  = 1;
   int loopLimit  = 0;
   logic          prevValid = 1'b0;
   logic          prevReady = 1'b0;
   logic [DW-1:0] prevDout  = '0;

   sig_capture_player #(
      .A_WIDTH (AW),
      .D_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .loop       (loop),
      .en         (en),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Negedge monitor: drives ready/loop for the next edge, records handshakes and done pulses,
   // and confirms dout holds still while the consumer stalls.
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
         end else begin
            dout_ready = (readyMode == 2) ? !dout_ready : (readyMode == 1);
            if (prevValid && !prevReady) begin
               checkOutput("stallValid", int'(dout_valid), 1);
               checkOutput("stallStable", int'(dout), int'(prevDout));
            end
            if (dout_valid && dout_ready) begin
               got.push_back(int'(dout));
               gotCyc.push_back(cycle);
            end
            loop = (got.size() < loopLimit);
            if (done) doneCount++;
            prevValid = dout_valid;
            prevReady = dout_ready;
            prevDout  = dout;
         end
      end
   end

   task automatic clearRun();
      got.delete();
      gotCyc.delete();
      doneCount = 0;
   endtask

   // Capture stim[0..n-1]; optionally raise en on the start cycle and pulse start mid-capture.
   task automatic applyStimulus(input int lenVal, input int n, input bit enOnStart, input bit pulseMid);
      start = 1'b1;
      len   = AW'(lenVal);
      en    = enOnStart;
      din   = 8'd99;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busyRecord", int'(busy), 1);
      for (int i = 0; i < n; i++) begin
         if (pulseMid && i == 2) begin
            en    = 1'b0;
            start = 1'b1;
            len   = AW'(1);
            @(posedge clk); #1;
            start = 1'b0;
         end
         en  = 1'b1;
         din = DW'(stim[i]);
         @(posedge clk); #1;
      end
      en  = 1'b0;
      din = '0;
   endtask

   task automatic waitForDone(input string tag, input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk); #1;
         if (doneCount > 0) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_doneSeen"}, int'(seen), 1);
      repeat (3) @(negedge clk);
      #1;
      checkOutput({tag, "_doneOnce"}, doneCount, 1);
      checkOutput({tag, "_busyLow"}, int'(busy), 0);
      checkOutput({tag, "_validLow"}, int'(dout_valid), 0);
   endtask

   task automatic checkStream(input string tag, input int n);
      checkOutput({tag, "_count"}, got.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < got.size()) checkOutput($sformatf("%s_s%0d", tag, i), got[i], expd[i]);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstValid", int'(dout_valid), 0);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstDout", int'(dout), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: len=4, continuous strobe and ready
      clearRun();
      readyMode = 1;
      stim[0] = 10; stim[1] = 20; stim[2] = 30; stim[3] = 40;
      expd[0] = 10; expd[1] = 20; expd[2] = 30; expd[3] = 40;
      applyStimulus(4, 4, 1'b0, 1'b0);
      waitForDone("t1", 40);
      checkStream("t1", 4);
      if (gotCyc.size() == 4) checkOutput("t1_noBubble", gotCyc[3] - gotCyc[0], 3);
      checkOutput("t1_doutHeld", int'(dout), 40);

      // 2: same capture with ready toggling every cycle
      clearRun();
      readyMode = 2;
      applyStimulus(4, 4, 1'b0, 1'b0);
      waitForDone("t2", 60);
      checkStream("t2", 4);

      // 3: len=0 means full depth (8 samples at A_WIDTH=3)
      clearRun();
      readyMode = 1;
      for (int i = 0; i < 8; i++) begin
         stim[i] = i;
         expd[i] = i;
      end
      applyStimulus(0, 8, 1'b0, 1'b0);
      waitForDone("t3", 60);
      checkStream("t3", 8);

      // 4: len=3 looped twice then released, no gap at the wrap
      clearRun();
      loopLimit = 4;
      stim[0] = 1; stim[1] = 2; stim[2] = 3;
      expd[0] = 1; expd[1] = 2; expd[2] = 3; expd[3] = 1; expd[4] = 2; expd[5] = 3;
      applyStimulus(3, 3, 1'b0, 1'b0);
      waitForDone("t4", 60);
      checkStream("t4", 6);
      if (gotCyc.size() == 6) checkOutput("t4_noBubble", gotCyc[5] - gotCyc[0], 5);
      loopLimit = 0;

      // 5: start+en in IDLE does not write; start pulses in RECORD and PLAY are ignored
      clearRun();
      stim[0] = 5; stim[1] = 6; stim[2] = 7; stim[3] = 8;
      expd[0] = 5; expd[1] = 6; expd[2] = 7; expd[3] = 8;
      applyStimulus(4, 4, 1'b1, 1'b1);
      start = 1'b1;
      len   = AW'(2);
      @(posedge clk); #1;
      start = 1'b0;
      waitForDone("t5", 60);
      checkStream("t5", 4);

      // 6: reset mid-PLAY, then a fresh capture
      clearRun();
      readyMode = 0;
      stim[0] = 1; stim[1] = 2; stim[2] = 3; stim[3] = 4;
      applyStimulus(4, 4, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t6_stalledValid", int'(dout_valid), 1);
      rst = 1'b1;
      #1;
      checkOutput("t6_rstValid", int'(dout_valid), 0);
      checkOutput("t6_rstBusy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      clearRun();
      readyMode = 1;
      @(posedge clk); #1;
      stim[0] = 77; stim[1] = 88;
      expd[0] = 77; expd[1] = 88;
      applyStimulus(2, 2, 1'b0, 1'b0);
      waitForDone("t6", 40);
      checkStream("t6", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
